// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//   Stretches single-cycle event strobes into visible LED-length levels.
//   Each channel runs an independent IDLE/HOLD state machine with its own
//   down-counter; a strobe arriving while a channel is already holding
//   restarts the hold time without dropping the output.
//
// Parameters
//   CHANNELS    : number of independent channels
//   HOLD_CYCLES : output high time in clk cycles (legal 1 .. 2**CNT_W)
//   CNT_W       : per-channel down-counter width
//
// Ports
//   clk         : system clock, all logic on posedge
//   reset       : asynchronous, active-high reset
//   pulse_in    : per-channel event strobes, synchronous to clk
//   led_out     : registered stretched level per channel
//   busy        : registered OR of all channels currently holding
//   overrun_clr : (optional) clears all overrun flags on the next edge
//   overrun     : (optional) sticky per-channel retrigger flags
//
// Optional feature
//   Define PULSE_STRETCH_OVERRUN_EN to add the overrun_clr/overrun ports and
//   the sticky retrigger-detection logic. Without it neither exists.
// -----------------------------------------------------------------------------
module pulse_stretch #(
   parameter int CHANNELS    = 4,
   parameter int HOLD_CYCLES = 12500000,
   parameter int CNT_W       = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] pulse_in,
`ifdef PULSE_STRETCH_OVERRUN_EN
   input  logic                overrun_clr,
   output logic [CHANNELS-1:0] overrun,
`endif
   output logic [CHANNELS-1:0] led_out,
   output logic                busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   // Counter counts remaining cycles after the current one, hence the -1.
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [CHANNELS-1:0] state_q;
   logic [CHANNELS-1:0] state_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   always_comb begin
      state_d = state_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (state_q[i] == ST_IDLE) begin
            if (pulse_in[i]) begin
               state_d[i] = ST_HOLD;
               cnt_d[i]   = RELOAD;
            end
         end else begin
            // Retrigger wins over expiry, even on the terminal count.
            if (pulse_in[i]) begin
               cnt_d[i] = RELOAD;
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
               state_d[i] = ST_IDLE;
            end
         end
      end
   end

   // led_out and busy are registered copies of the next state so they change
   // on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
         led_out <= '0;
         busy    <= 1'b0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         led_out <= state_d;
         busy    <= |state_d;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

`ifdef PULSE_STRETCH_OVERRUN_EN
   logic [CHANNELS-1:0] retrig;

   always_comb begin
      retrig = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         retrig[i] = (state_q[i] == ST_HOLD) && pulse_in[i];
      end
   end

   // A retrigger in the same cycle as a clear leaves its bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= '0;
      end else begin
         overrun <= (overrun & ~{CHANNELS{overrun_clr}}) | retrig;
      end
   end
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
module tb_pulse_stretch;

   localparam int NI = 3;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          overrun_clr;
   logic [CH-1:0] pulse_in;
   logic [CH-1:0] led [NI];
   logic          busy [NI];
   logic [CH-1:0] ovr [NI];

   int errors = 0;
   int checks = 0;
   int k = 0;
   int last_p [NI][CH];
   logic [CH-1:0] ovr_m [NI];

   always #5 clk = ~clk;

   // Three builds share stimulus: nominal, minimum hold, and maximum hold for
   // the counter width.
   pulse_stretch #(.CHANNELS(CH), .HOLD_CYCLES(4), .CNT_W(3)) dut0 (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
`ifdef PULSE_STRETCH_OVERRUN_EN
      .overrun_clr(overrun_clr), .overrun(ovr[0]),
`endif
      .led_out(led[0]), .busy(busy[0]));

   pulse_stretch #(.CHANNELS(CH), .HOLD_CYCLES(1), .CNT_W(1)) dut1 (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
`ifdef PULSE_STRETCH_OVERRUN_EN
      .overrun_clr(overrun_clr), .overrun(ovr[1]),
`endif
      .led_out(led[1]), .busy(busy[1]));

   pulse_stretch #(.CHANNELS(CH), .HOLD_CYCLES(8), .CNT_W(3)) dut2 (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
`ifdef PULSE_STRETCH_OVERRUN_EN
      .overrun_clr(overrun_clr), .overrun(ovr[2]),
`endif
      .led_out(led[2]), .busy(busy[2]));

`ifndef PULSE_STRETCH_OVERRUN_EN
   initial for (int i = 0; i < NI; i++) ovr[i] = '0;
`endif

   function automatic int hold_of(input int i);
      case (i)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   // Output is high after edge k iff the latest accepted pulse was at most
   // HOLD-1 edges ago.
   function automatic logic [CH-1:0] led_exp(input int i);
      logic [CH-1:0] r;
      int d;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         d = k - last_p[i][c];
         r[c] = (d >= 0) && (d <= hold_of(i) - 1);
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s @edge%0d observed=%b expected=%b", tag, k, obs, exp_v);
      end
   endtask

   task automatic check_all();
      logic [CH-1:0] e;
      for (int i = 0; i < NI; i++) begin
         e = led_exp(i);
         chk($sformatf("led%0d", i), led[i], e);
         chk($sformatf("busy%0d", i), {3'b000, busy[i]}, {3'b000, |e});
`ifdef PULSE_STRETCH_OVERRUN_EN
         chk($sformatf("overrun%0d", i), ovr[i], ovr_m[i]);
`endif
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         ovr_m[i] = '0;
         for (int c = 0; c < CH; c++) last_p[i][c] = -1000;
      end
   endtask

   task automatic edge_step();
      int d;
      logic held;
      @(posedge clk);
      k++;
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            if (overrun_clr) ovr_m[i] = '0;
            for (int c = 0; c < CH; c++) begin
               d = (k - 1) - last_p[i][c];
               held = (d >= 0) && (d <= hold_of(i) - 1);
               if (pulse_in[c] && held) ovr_m[i][c] = 1'b1;
               if (pulse_in[c]) last_p[i][c] = k;
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic step(input logic [CH-1:0] p, input logic clr);
      pulse_in    = p;
      overrun_clr = clr;
      edge_step();
   endtask

   // Called 1 time unit after an edge; asserts reset mid-cycle.
   task automatic async_reset(input int hold_edges);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      for (int n = 0; n < hold_edges; n++) step('1, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      pulse_in    = '0;
      overrun_clr = 1'b0;
      model_reset();
      #2;
      reset = 1'b1;
      #1;
      check_all();
      step('1, 1'b0);
      step('1, 1'b0);
      reset = 1'b0;
      k = 0;

      // Isolated pulse ch0, retrigger ch1 mid-hold, ch2 retrigger on terminal count.
      repeat (9) step('0, 1'b0);
      step(4'b0111, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      repeat (8) step('0, 1'b0);

      // Clear alone, then clear colliding with a retrigger on ch1.
      step('0, 1'b1);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b1);
      step('0, 1'b0);
      step('0, 1'b1);
      repeat (10) step('0, 1'b0);

      // All channels fire, then reset mid-hold; stretch must not resume.
      step(4'b1111, 1'b0);
      step('0, 1'b0);
      async_reset(2);
      repeat (5) step('0, 1'b0);
      step(4'b1000, 1'b0);
      repeat (10) step('0, 1'b0);

      // Input held high for six cycles.
      repeat (6) step(4'b0001, 1'b0);
      repeat (12) step('0, 1'b0);

      // Spaced pulses: minimum-hold build reproduces them delayed.
      step(4'b0001, 1'b0);
      step('0, 1'b0);
      step(4'b0001, 1'b0);
      step('0, 1'b1);
      repeat (10) step('0, 1'b0);

      // Randomized traffic with occasional clears and resets.
      for (int n = 0; n < 600; n++) begin
         logic [CH-1:0] p;
         for (int c = 0; c < CH; c++) p[c] = ($urandom_range(0, 5) == 0);
         step(p, $urandom_range(0, 15) == 0);
         if ($urandom_range(0, 80) == 0) async_reset($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent channels.
REQ-002 SHALL have parameter HOLD_CYCLES, default 12500000: output high time in clk cycles (0.25 s at 50 MHz); legal range 1..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 24: per-channel down-counter width.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port pulse_in, input, CHANNELS: single-cycle event strobes (e.g. from button debouncers), synchronous to clk.
REQ-007 SHALL have port led_out, output, CHANNELS: registered stretched level per channel, intended to drive board LEDs.
REQ-008 SHALL have port busy, output, 1: registered OR of all channel HOLD states.

Function
REQ-009 SHALL implement, per channel, an independent 2-state FSM: IDLE, HOLD.
REQ-010 SHALL, in IDLE, on pulse_in[i]=1: go to HOLD, load counter with HOLD_CYCLES-1, and set led_out[i]=1 on the next clock edge (1-cycle latency).
REQ-011 SHALL, in HOLD with pulse_in[i]=0 and counter>0: decrement counter by 1 and keep led_out[i]=1.
REQ-012 SHALL, in HOLD with pulse_in[i]=0 and counter=0: go to IDLE and clear led_out[i] on that edge.
REQ-013 SHALL, in HOLD with pulse_in[i]=1 at any counter value, including 0: reload HOLD_CYCLES-1 and stay in HOLD (retrigger), with no low glitch on led_out[i].
REQ-014 SHALL hold led_out[i] high for exactly HOLD_CYCLES cycles after an isolated single-cycle pulse.
REQ-015 SHALL, for a pulse_in[i] held high for N cycles, hold led_out[i] high for N+HOLD_CYCLES-1 cycles.
REQ-016 SHALL, with HOLD_CYCLES=1, reproduce the input pulse delayed by 1 cycle.
REQ-017 SHALL keep channels fully independent: simultaneous pulses on several channels are all accepted in the same cycle.
REQ-018 SHALL update busy on the same edge as led_out, so busy equals the OR of the next-state led_out bits.
REQ-019 SHALL never let a counter underflow or wrap; the counter saturates at 0 in IDLE.

Reset
REQ-020 SHALL, on reset=1 (asynchronous), force all FSMs to IDLE, all counters to 0, and led_out, busy, and overrun (if present) to 0.
REQ-021 SHALL abort any HOLD in progress when reset asserts mid-operation; the aborted stretch is not resumed after reset is released.
REQ-022 SHALL ignore pulse_in while reset=1; the first pulse is accepted on the first clk edge after reset deasserts.

Configuration
REQ-023 SHALL, with PULSE_STRETCH_OVERRUN_EN defined, add input overrun_clr (1 bit) and output overrun (CHANNELS bits, registered).
REQ-024 SHALL, in that configuration, set overrun[i] sticky when a retrigger occurs per REQ-013; overrun_clr=1 clears all bits on the next edge, and a retrigger in the same cycle takes priority (bit sets).
REQ-025 SHALL, without PULSE_STRETCH_OVERRUN_EN, have neither port nor any overrun logic; all other behaviour is identical.

Verification (CHANNELS=4, HOLD_CYCLES=4, CNT_W=3 unless noted)
REQ-026 SHALL cover: a 1-cycle pulse on ch0 at cycle 10 -> led_out[0] high in cycles 11-14, low at 15; busy tracks it; other channels stay 0.
REQ-027 SHALL cover: ch1 pulses at cycles 10 and 13 -> led_out[1] high in cycles 11-17 with no gap; overrun[1]=1 from cycle 14 (macro on).
REQ-028 SHALL cover: ch2 pulse at cycle 10 and again on the terminal cycle 14 -> led_out[2] continuous from 11 through 18.
REQ-029 SHALL cover: pulses on all channels at cycle 10 and reset asserted asynchronously at cycle 12.5 -> all led_out and busy 0 immediately; a new ch3 pulse at 20 -> led_out[3] high in 21-24.
REQ-030 SHALL cover: pulse_in[0] held high for cycles 10-15 -> led_out[0] high in 11-19.
REQ-031 SHALL cover: HOLD_CYCLES=1 with pulses on ch0 at cycles 5 and 7 -> led_out[0] high only in cycles 6 and 8; overrun_clr at 9 with no pulse -> overrun=0 at 10.
